// File: rtl/vga_pkg.sv
// VGA output core: timing defaults, derived totals and register map.
package vga_pkg;

  localparam int XY_W = 11;

  localparam int DEF_CD         = 12;
  localparam int DEF_PIPE_DELAY = 2;
  localparam int DEF_CLK_DIV    = 4;

  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SW   = 96;
  localparam int DEF_H_BP   = 48;

  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SW   = 2;
  localparam int DEF_V_BP   = 33;

  function automatic int span_total(
    input int disp,
    input int fp,
    input int sw,
    input int bp
  );
    return disp + fp + sw + bp;
  endfunction

  localparam int H_TOTAL =
    span_total(DEF_H_DISP, DEF_H_FP, DEF_H_SW, DEF_H_BP);
  localparam int V_TOTAL =
    span_total(DEF_V_DISP, DEF_V_FP, DEF_V_SW, DEF_V_BP);

  localparam int HS_START = DEF_H_DISP + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SW - 1;
  localparam int VS_START = DEF_V_DISP + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SW - 1;

  localparam logic [1:0] REG_CTRL = 2'b00;
  localparam logic [1:0] REG_BG   = 2'b01;

endpackage

// File: rtl/vga_frame_counter.sv
// Pixel-rate frame counter: clock divider, x/y scan position,
// frame-start pulse and raw (undelayed) sync/blank decode.
module vga_frame_counter
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SW    = DEF_H_SW,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SW    = DEF_V_SW,
  parameter int V_BP    = DEF_V_BP
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XY_W-1:0] o_x,
  output logic [XY_W-1:0] o_y,
  output logic            o_frame_start,
  output logic            o_hs_n,
  output logic            o_vs_n,
  output logic            o_von
);

  localparam int HT  = span_total(H_DISP, H_FP, H_SW, H_BP);
  localparam int VT  = span_total(V_DISP, V_FP, V_SW, V_BP);
  localparam int HSS = H_DISP + H_FP;
  localparam int HSE = HSS + H_SW - 1;
  localparam int VSS = V_DISP + V_FP;
  localparam int VSE = VSS + V_SW - 1;
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]   r_div;
  logic [XY_W-1:0] r_x;
  logic [XY_W-1:0] r_y;
  logic            r_fs;
  logic            w_tick;
  logic            w_eol;
  logic            w_eof;

  assign w_tick = (r_div == DW'(CLK_DIV - 1));
  assign w_eol  = (r_x == XY_W'(HT - 1));
  assign w_eof  = (r_y == XY_W'(VT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x  <= '0;
      r_y  <= '0;
      r_fs <= 1'b0;
    end else begin
      r_fs <= w_tick & w_eol & w_eof;
      if (w_tick) begin
        if (w_eol) begin
          r_x <= '0;
          r_y <= w_eof ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_fs;

  assign o_hs_n = !((r_x >= XY_W'(HSS)) && (r_x <= XY_W'(HSE)));
  assign o_vs_n = !((r_y >= XY_W'(VSS)) && (r_y <= XY_W'(VSE)));
  assign o_von  = (r_x < XY_W'(H_DISP)) && (r_y < XY_W'(V_DISP));

endmodule

// File: rtl/vga_out_core.sv
// Final video stage: frame counter, sync/blank alignment to the
// upstream pipeline, background override and registered VGA pins.
module vga_out_core
  import vga_pkg::*;
#(
  parameter int CD         = DEF_CD,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int H_DISP     = DEF_H_DISP,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SW       = DEF_H_SW,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_DISP     = DEF_V_DISP,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SW       = DEF_V_SW,
  parameter int V_BP       = DEF_V_BP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            write,
  input  logic [13:0]     addr,
  input  logic [31:0]     wr_data,
  output logic [XY_W-1:0] x,
  output logic [XY_W-1:0] y,
  output logic            frame_start,
  input  logic [CD-1:0]   si_rgb,
  output logic            hsync,
  output logic            vsync,
  output logic [CD-1:0]   rgb
);

  logic          w_hs_n;
  logic          w_vs_n;
  logic          w_von;
  logic          w_hs_d;
  logic          w_vs_d;
  logic          w_von_d;
  logic          w_wr;
  logic [CD-1:0] w_rgb_nxt;
  logic          w_unused;
  logic          r_ctrl;
  logic [CD-1:0] r_bg;

  vga_frame_counter #(
    .CLK_DIV (CLK_DIV),
    .H_DISP  (H_DISP),
    .H_FP    (H_FP),
    .H_SW    (H_SW),
    .H_BP    (H_BP),
    .V_DISP  (V_DISP),
    .V_FP    (V_FP),
    .V_SW    (V_SW),
    .V_BP    (V_BP)
  ) u_cnt (
    .clk           (clk),
    .reset         (reset),
    .o_x           (x),
    .o_y           (y),
    .o_frame_start (frame_start),
    .o_hs_n        (w_hs_n),
    .o_vs_n        (w_vs_n),
    .o_von         (w_von)
  );

  // Delay timing by the upstream latency so it lines up with si_rgb.
  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign w_hs_d  = w_hs_n;
      assign w_vs_d  = w_vs_n;
      assign w_von_d = w_von;
    end else begin : g_dly
      logic [PIPE_DELAY-1:0] r_hs_sr;
      logic [PIPE_DELAY-1:0] r_vs_sr;
      logic [PIPE_DELAY-1:0] r_von_sr;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_hs_sr  <= '1;
          r_vs_sr  <= '1;
          r_von_sr <= '0;
        end else begin
          r_hs_sr[0]  <= w_hs_n;
          r_vs_sr[0]  <= w_vs_n;
          r_von_sr[0] <= w_von;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            r_hs_sr[i]  <= r_hs_sr[i-1];
            r_vs_sr[i]  <= r_vs_sr[i-1];
            r_von_sr[i] <= r_von_sr[i-1];
          end
        end
      end

      assign w_hs_d  = r_hs_sr[PIPE_DELAY-1];
      assign w_vs_d  = r_vs_sr[PIPE_DELAY-1];
      assign w_von_d = r_von_sr[PIPE_DELAY-1];
    end
  endgenerate

  assign w_wr     = cs & write;
  assign w_unused = ^{addr, wr_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= 1'b0;
      r_bg   <= '0;
    end else if (w_wr) begin
      case (addr[1:0])
        REG_CTRL: r_ctrl <= wr_data[0];
        REG_BG:   r_bg   <= wr_data[CD-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_rgb_nxt = '0;
    if (w_von_d) begin
      w_rgb_nxt = r_ctrl ? r_bg : si_rgb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else begin
      hsync <= w_hs_d;
      vsync <= w_vs_d;
      rgb   <= w_rgb_nxt;
    end
  end

endmodule

// File: tb/tb_vga_out_core.sv
// Scoreboard bench for vga_out_core on a shrunken raster
// (25x11 total, 16x6 visible) so whole frames fit in a short run.
module tb_vga_out_core;

  localparam int CD    = 12;
  localparam int PD    = 2;
  localparam int CDIV  = 4;
  localparam int HSW   = 4;
  localparam int VSW   = 2;
  localparam int FRAME = 1100;

  localparam int S_X  = 0;
  localparam int S_Y  = 1;
  localparam int S_HS = 2;
  localparam int S_VS = 3;
  localparam int S_RGB = 4;
  localparam int S_FS = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cs = 1'b0;
  logic          write = 1'b0;
  logic [13:0]   addr = '0;
  logic [31:0]   wr_data = '0;
  logic [10:0]   x;
  logic [10:0]   y;
  logic          frame_start;
  logic [CD-1:0] si_rgb;
  logic          hsync;
  logic          vsync;
  logic [CD-1:0] rgb;
  logic [CD-1:0] r_p1 = '0;
  logic [CD-1:0] r_p2 = '0;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t  q[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_err = 0;
  int    hs_run = 0;
  int    vs_run = 0;
  int    last_fs = -1;
  logic  prev_fs = 1'b0;

  vga_out_core #(
    .CD(CD), .PIPE_DELAY(PD), .CLK_DIV(CDIV),
    .H_DISP(16), .H_FP(2), .H_SW(HSW), .H_BP(3),
    .V_DISP(6), .V_FP(1), .V_SW(VSW), .V_BP(2)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .write(write),
    .addr(addr), .wr_data(wr_data), .x(x), .y(y),
    .frame_start(frame_start), .si_rgb(si_rgb),
    .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #5 clk = ~clk;

  // Upstream model: pattern from x/y, PD clocks late.
  always @(posedge clk) begin
    r_p1 <= {x[3:0], y[3:0], 4'hA};
    r_p2 <= r_p1;
  end
  assign si_rgb = r_p2;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] sig_val(input int s);
    case (s)
      S_X:     return 32'(x);
      S_Y:     return 32'(y);
      S_HS:    return 32'(hsync);
      S_VS:    return 32'(vsync);
      S_RGB:   return 32'(rgb);
      default: return 32'(frame_start);
    endcase
  endfunction

  task automatic push(input int c, input int s, input int v,
                      input string n);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 4000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) chk("timeout", cyc, n);
  endtask

  task automatic wait_done(input int n);
    wait_cyc(n);
    while (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL missed %s at cycle %0d: expected %0h",
               q[0].name, q[0].cyc, q[0].val);
      void'(q.pop_front());
    end
  endtask

  task automatic wr(input int k, input logic c, input logic [1:0] a,
                    input logic [31:0] d);
    wait_cyc(k - 1);
    cs = c; write = 1'b1; addr = {12'd0, a}; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
  endtask

  // Monitor: cyc = clocks since reset release, sampled 1 after edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        cyc = 0; hs_run = 0; vs_run = 0;
        last_fs = -1; prev_fs = 1'b0;
      end else begin
        cyc++;
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          chk(q[i].name, sig_val(q[i].sig), q[i].val);
          q.delete(i);
        end
      end
      if (!reset) begin
        if (!hsync) hs_run++;
        else if (hs_run != 0) begin
          chk("hs_width", hs_run, HSW * CDIV);
          hs_run = 0;
        end
        if (!vsync) vs_run++;
        else if (vs_run != 0) begin
          chk("vs_width", vs_run, VSW * 25 * CDIV);
          vs_run = 0;
        end
        if (frame_start) begin
          chk("fs_single", prev_fs, 0);
          if (last_fs >= 0) chk("fs_period", cyc - last_fs, FRAME);
          last_fs = cyc;
        end
        prev_fs = frame_start;
      end
    end
  end

  initial begin
    push(0, S_X, 0, "rst_x");
    push(0, S_Y, 0, "rst_y");
    push(0, S_HS, 1, "rst_hs");
    push(0, S_VS, 1, "rst_vs");
    push(0, S_RGB, 0, "rst_rgb");
    push(0, S_FS, 0, "rst_fs");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    push(3, S_X, 0, "x_before_tick");
    push(4, S_X, 1, "x_first_tick");
    push(2, S_RGB, 0, "rgb_pipe_empty");
    push(3, S_RGB, 'h00A, "rgb_00");
    push(7, S_RGB, 'h10A, "rgb_10");
    push(63, S_RGB, 'hF0A, "rgb_last_active");
    push(67, S_RGB, 'h000, "rgb_hblank");
    push(72, S_X, 18, "x_hs_start");
    push(74, S_HS, 1, "hs_pre");
    push(75, S_HS, 0, "hs_fall");
    push(90, S_HS, 0, "hs_last_low");
    push(91, S_HS, 1, "hs_rise");
    push(99, S_X, 24, "x_eol");
    push(99, S_Y, 0, "y_eol");
    push(100, S_X, 0, "x_wrap");
    push(100, S_Y, 1, "y_inc");
    push(123, S_RGB, 'h51A, "rgb_51");
    push(515, S_RGB, 'h35A, "rgb_35");
    push(611, S_RGB, 'h000, "rgb_vblank");
    push(700, S_Y, 7, "y_vs_start");
    push(702, S_VS, 1, "vs_pre");
    push(703, S_VS, 0, "vs_fall");
    push(902, S_VS, 0, "vs_last_low");
    push(903, S_VS, 1, "vs_rise");
    push(1099, S_FS, 0, "fs_pre");
    push(1100, S_FS, 1, "fs_pulse");
    push(1100, S_X, 0, "fs_x");
    push(1100, S_Y, 0, "fs_y");
    push(1101, S_FS, 0, "fs_post");
    push(2200, S_FS, 1, "fs_pulse2");
    wait_done(2205);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push(12, S_RGB, 'h20A, "rgb_before_ctrl");
    push(13, S_RGB, 'hF00, "rgb_bg_on");
    push(40, S_RGB, 'hF00, "rgb_bg_hold");
    push(67, S_RGB, 'h000, "rgb_bg_blank");
    push(110, S_RGB, 'hF00, "rgb_bg_last");
    push(111, S_RGB, 'h21A, "rgb_stream_back");
    push(121, S_RGB, 'h41A, "rgb_cs0_ignored");
    push(125, S_RGB, 'h51A, "rgb_addr10_ignored");
    push(129, S_RGB, 'h61A, "rgb_addr11_ignored");
    push(141, S_RGB, 'hF00, "rgb_bg_kept");
    push(148, S_RGB, 'hF00, "rgb_pre_reset");
    wr(10, 1'b1, 2'b01, 32'h0000_0F00);
    wr(12, 1'b1, 2'b00, 32'h1);
    wr(110, 1'b1, 2'b00, 32'h0);
    wr(120, 1'b0, 2'b00, 32'h1);
    wr(124, 1'b1, 2'b10, 32'h1);
    wr(128, 1'b1, 2'b11, 32'h0000_0ABC);
    wr(140, 1'b1, 2'b00, 32'h1);
    wait_done(148);

    #1 reset = 1'b1;
    #1;
    chk("async_x", x, 0);
    chk("async_y", y, 0);
    chk("async_rgb", rgb, 0);
    chk("async_hs", hsync, 1);
    chk("async_vs", vsync, 1);
    chk("async_fs", frame_start, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push(3, S_RGB, 'h00A, "ctrl_cleared");
    push(3, S_X, 0, "rel_x_hold");
    push(4, S_X, 1, "rel_x_tick");
    push(10, S_RGB, 'h10A, "rgb_pre_ctrl2");
    push(11, S_RGB, 'h000, "bg_cleared");
    wr(10, 1'b1, 2'b00, 32'h1);
    wait_done(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
